pb_debounce: RTL and testbench
==============================

Name: pb_debounce

Overview:
- Conditions a raw active-low push-button before the release-edge detector in the button path.
- Synchronizes the raw input, then rejects bounce with a stable-level counter.
- Drives a clean level, PB_clean, into the release detector's PB input.
- Also emits one-cycle press, long-press and short-release pulses for the command/tour-start logic.

Parameters:
DEBOUNCE_CYC, 50000, consecutive stable synchronized cycles needed to accept a level change (1 ms at 50 MHz); legal range >= 2
LONG_CYC, 25000000, debounced-pressed cycles before long_press fires (0.5 s at 50 MHz); legal range >= 1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
PB  input  1  raw button, active-low (1 = not pressed), asynchronous to clk
PB_clean  output  1  debounced level, same polarity as PB; feeds the release detector
press  output  1  one-cycle pulse on the accepted press
long_press  output  1  one-cycle pulse once per press, after LONG_CYC pressed cycles
short_release  output  1  one-cycle pulse on the accepted release, only if long_press did not fire during that press

Behaviour:
- Reset is rst_n, asynchronous, active-low; the clock is clk.
- Reset values:
  - Both synchronizer flops = 1.
  - State = IDLE.
  - Counters = 0, long_done = 0.
  - PB_clean = 1; press, long_press, short_release = 0.
- All outputs are registered.
- Synchronizer: two flops, PB -> s1 -> s2; s2 is pb_sync.
- Debounce counter dcnt: width $clog2(DEBOUNCE_CYC).
- Hold counter hcnt: width $clog2(LONG_CYC)+1.
- States:
  - IDLE (PB_clean=1): pb_sync==0 -> CHK_LO, dcnt<=0.
  - CHK_LO:
    - pb_sync==1 -> IDLE (bounce rejected), dcnt<=0.
    - Else if dcnt==DEBOUNCE_CYC-1 -> PRESSED; PB_clean<=0, press<=1, hcnt<=0, long_done<=0.
    - Else dcnt++.
  - PRESSED (PB_clean=0):
    - hcnt++ each cycle until long_done.
    - When hcnt==LONG_CYC-1 and !long_done: long_press<=1, long_done<=1; hcnt then holds.
    - pb_sync==1 -> CHK_HI, dcnt<=0.
  - CHK_HI:
    - pb_sync==0 -> PRESSED (bounce rejected); hcnt frozen, not cleared.
    - Else if dcnt==DEBOUNCE_CYC-1 -> IDLE; PB_clean<=1, short_release<=!long_done.
    - Else dcnt++.
- Pulses are high for exactly one cycle, then return to 0.
- Latency: number PB's first low sampling edge as edge 1.
  - pb_sync goes low at edge 2 and CHK_LO is entered at edge 3.
  - PB_clean falls and press asserts at edge DEBOUNCE_CYC+3.
  - Release is symmetric: PB_clean rises at the (DEBOUNCE_CYC+3)th edge after PB is first sampled high.
- long_press asserts at edge E+LONG_CYC, where E is the PB_clean falling edge, provided PRESSED is held continuously.
- At most one long_press per accepted press. long_done clears only on the next CHK_LO->PRESSED transition.
- A bounce in CHK_HI returning to PRESSED must not re-assert press.
- hcnt does not advance while in CHK_HI.
- Reset asserted mid-operation forces the reset values immediately; any partial count is discarded.
- PB_clean changes only at accepted transitions, so the downstream release detector sees exactly one rising edge per accepted release.

Test Plan (DEBOUNCE_CYC=4, LONG_CYC=20; edge 1 = first edge sampling PB=0):
1. Clean press: PB=0 held 40 cycles -> PB_clean falls at edge 7; press=1 only after edge 7; long_press=1 only after edge 27; long_press never repeats; short_release stays 0.
2. Bounce reject: PB=0 for 3 edges, then 1 -> PB_clean stays 1; press, long_press and short_release all stay 0.
3. Short press: PB=0 edges 1-10, PB=1 from edge 11 -> press at edge 7; PB_clean rises and short_release=1 at edge 17 for one cycle; long_press stays 0.
4. Long hold then release: PB=0 edges 1-30, then 1 -> long_press once at edge 27; PB_clean rises at edge 37; short_release stays 0.
5. Release bounce: PB=0, then PB=1 for 2 edges mid-hold, then 0 again -> PB_clean stays 0, no second press, no short_release; long_press timing is delayed by the CHK_HI cycles.
6. Reset in CHK_LO: assert rst_n=0 at edge 5 of a press -> PB_clean=1 and all pulses 0 immediately; after deassert with PB=0, PB_clean falls again only DEBOUNCE_CYC+3 edges later.

Source files
------------

// File: rtl/pb_debounce.sv
// Push-button conditioner: two-flop synchronizer, stable-level debounce FSM,
// and one-cycle press / long-press / short-release pulses. PB and PB_clean
// are active-low (1 = not pressed).
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  IDLE    | button released, PB_clean = 1
//  CHK_LO  | synchronized input low, counting stable cycles to accept press
//  PRESSED | press accepted, PB_clean = 0, hold counter running
//  CHK_HI  | synchronized input high, counting stable cycles to accept release
module pb_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 50000,
    parameter int unsigned LONG_CYC     = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic PB,
    output logic PB_clean,
    output logic press,
    output logic long_press,
    output logic short_release
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYC);
    localparam int unsigned HW = $clog2(LONG_CYC) + 1;

    localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYC - 1);
    localparam logic [DW-1:0] DCNT_ONE = DW'(1);
    localparam logic [HW-1:0] HCNT_MAX = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] HCNT_ONE = HW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHK_LO  = 2'd1,
        PRESSED = 2'd2,
        CHK_HI  = 2'd3
    } state_t;

    logic          r_s1;
    logic          r_s2;
    logic          w_pb_sync;

    state_t        r_state,      w_state_nxt;
    logic [DW-1:0] r_dcnt,       w_dcnt_nxt;
    logic [HW-1:0] r_hcnt,       w_hcnt_nxt;
    logic          r_long_done,  w_long_done_nxt;
    logic          r_clean,      w_clean_nxt;
    logic          r_press,      w_press_nxt;
    logic          r_long,       w_long_nxt;
    logic          r_short,      w_short_nxt;

    assign w_pb_sync = r_s2;

    // Two-flop synchronizer for the asynchronous raw button; resets to released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= PB;
            r_s2 <= r_s1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_dcnt      <= '0;
            r_hcnt      <= '0;
            r_long_done <= 1'b0;
            r_clean     <= 1'b1;
            r_press     <= 1'b0;
            r_long      <= 1'b0;
            r_short     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dcnt      <= w_dcnt_nxt;
            r_hcnt      <= w_hcnt_nxt;
            r_long_done <= w_long_done_nxt;
            r_clean     <= w_clean_nxt;
            r_press     <= w_press_nxt;
            r_long      <= w_long_nxt;
            r_short     <= w_short_nxt;
        end
    end

    // Next-state logic; pulses default low so each lasts exactly one cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_dcnt_nxt      = r_dcnt;
        w_hcnt_nxt      = r_hcnt;
        w_long_done_nxt = r_long_done;
        w_clean_nxt     = r_clean;
        w_press_nxt     = 1'b0;
        w_long_nxt      = 1'b0;
        w_short_nxt     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (!w_pb_sync) begin
                    w_state_nxt = CHK_LO;
                    w_dcnt_nxt  = '0;
                end
            end
            CHK_LO: begin
                if (w_pb_sync) begin
                    w_state_nxt = IDLE;
                    w_dcnt_nxt  = '0;
                end else if (r_dcnt == DCNT_MAX) begin
                    w_state_nxt     = PRESSED;
                    w_clean_nxt     = 1'b0;
                    w_press_nxt     = 1'b1;
                    w_hcnt_nxt      = '0;
                    w_long_done_nxt = 1'b0;
                end else begin
                    w_dcnt_nxt = r_dcnt + DCNT_ONE;
                end
            end
            PRESSED: begin
                // Hold timer stops for good once long_press has fired.
                if (!r_long_done) begin
                    if (r_hcnt == HCNT_MAX) begin
                        w_long_nxt      = 1'b1;
                        w_long_done_nxt = 1'b1;
                    end else begin
                        w_hcnt_nxt = r_hcnt + HCNT_ONE;
                    end
                end
                if (w_pb_sync) begin
                    w_state_nxt = CHK_HI;
                    w_dcnt_nxt  = '0;
                end
            end
            CHK_HI: begin
                // Bounce back to PRESSED keeps hcnt and does not re-issue press.
                if (!w_pb_sync) begin
                    w_state_nxt = PRESSED;
                end else if (r_dcnt == DCNT_MAX) begin
                    w_state_nxt = IDLE;
                    w_clean_nxt = 1'b1;
                    w_short_nxt = !r_long_done;
                end else begin
                    w_dcnt_nxt = r_dcnt + DCNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign PB_clean      = r_clean;
    assign press         = r_press;
    assign long_press    = r_long;
    assign short_release = r_short;

endmodule

// File: tb/tb_pb_debounce.sv
// Directed bench for pb_debounce with DEBOUNCE_CYC=4, LONG_CYC=20.
// Edge numbering: edge 1 is the first rising edge that samples the new PB value.
// Outputs are compared as {PB_clean, press, long_press, short_release}.
module tb_pb_debounce;

    logic clk;
    logic rst_n;
    logic PB;
    logic PB_clean;
    logic press;
    logic long_press;
    logic short_release;

    int n_vec;
    int n_err;

    pb_debounce #(
        .DEBOUNCE_CYC(4),
        .LONG_CYC    (20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PB           (PB),
        .PB_clean     (PB_clean),
        .press        (press),
        .long_press   (long_press),
        .short_release(short_release)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        PB    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        do_reset();
        for (int e = 1; e <= 6; e++) begin
            PB = 1'b1;
            @(posedge clk);
            #1;
            obs = {PB_clean, press, long_press, short_release};
            n_vec++;
            if (obs !== 4'b1000) begin
                n_err++;
                $display("FAIL reset_idle edge %0d got %b want %b", e, obs, 4'b1000);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] obs;
        logic [3:0] exp;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            PB = 1'b0;
            @(posedge clk);
            #1;
            exp = {(e < 7), (e == 7), (e == 27), 1'b0};
            obs = {PB_clean, press, long_press, short_release};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL clean_press edge %0d got %b want %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_bounce_reject();
        logic [3:0] obs;
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            PB = (e <= 3) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            obs = {PB_clean, press, long_press, short_release};
            n_vec++;
            if (obs !== 4'b1000) begin
                n_err++;
                $display("FAIL bounce_reject edge %0d got %b want %b", e, obs, 4'b1000);
            end
        end
    endtask

    task automatic test_short_press();
        logic [3:0] obs;
        logic [3:0] exp;
        do_reset();
        for (int e = 1; e <= 25; e++) begin
            PB = (e <= 10) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            exp = {!(e >= 7 && e < 17), (e == 7), 1'b0, (e == 17)};
            obs = {PB_clean, press, long_press, short_release};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL short_press edge %0d got %b want %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_long_release();
        logic [3:0] obs;
        logic [3:0] exp;
        do_reset();
        for (int e = 1; e <= 45; e++) begin
            PB = (e <= 30) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            exp = {!(e >= 7 && e < 37), (e == 7), (e == 27), 1'b0};
            obs = {PB_clean, press, long_press, short_release};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL long_release edge %0d got %b want %b", e, obs, exp);
            end
        end
    endtask

    // PB high for edges 11-12: CHK_HI occupies two cycles, hcnt frozen there,
    // so long_press slips from edge 27 to edge 29.
    task automatic test_release_bounce();
        logic [3:0] obs;
        logic [3:0] exp;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            PB = (e == 11 || e == 12) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            exp = {(e < 7), (e == 7), (e == 29), 1'b0};
            obs = {PB_clean, press, long_press, short_release};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL release_bounce edge %0d got %b want %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        logic [3:0] obs;
        logic [3:0] exp;
        do_reset();
        for (int e = 1; e <= 5; e++) begin
            PB = 1'b0;
            @(posedge clk);
            #1;
        end
        obs = {PB_clean, press, long_press, short_release};
        n_vec++;
        if (obs !== 4'b1000) begin
            n_err++;
            $display("FAIL chk_lo_before_reset got %b want %b", obs, 4'b1000);
        end
        rst_n = 1'b0;
        #1;
        obs = {PB_clean, press, long_press, short_release};
        n_vec++;
        if (obs !== 4'b1000) begin
            n_err++;
            $display("FAIL async_reset got %b want %b", obs, 4'b1000);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            PB = 1'b0;
            @(posedge clk);
            #1;
            exp = {(e < 7), (e == 7), 1'b0, 1'b0};
            obs = {PB_clean, press, long_press, short_release};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_restart edge %0d got %b want %b", e, obs, exp);
            end
        end
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        PB    = 1'b1;
        n_vec = 0;
        n_err = 0;

        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_short_press();
        test_long_release();
        test_release_bounce();
        test_reset_mid_press();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
